mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port 16-bit data memory (2K words) between two requesters:
  - port 0: the pipeline memory stage (loads, stores, push/pop);
  - port 1: the interrupt context-save unit (32-bit PC/flags push/pop).
- Splits 32-bit "double" accesses into two consecutive 16-bit word accesses.
- Drives memRead/memWrite/address/write-data toward the Memory instance and stalls the pipeline while port 0 waits.

Parameters:
- W, 16, data word width.
- AW, 11, memory word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request valid; held stable until p0_ack.
- p0_we  in  1  1 = write, 0 = read.
- p0_dbl  in  1  1 = two-word access, 0 = single word.
- p0_addr  in  AW  word address.
- p0_wdata  in  2W  write data; single access uses [W-1:0].
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  2W  read data, valid while p0_ack is high; single read zero-extended.
- p0_stall  out  1  p0_req & ~p0_ack (combinational), freezes pipeline.
- p1_req, p1_we, p1_dbl, p1_addr, p1_wdata, p1_ack, p1_rdata  same definitions as port 0 (no stall output).
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  W  memory write data.
- mem_rdata  in  W  memory read data, valid the cycle after memRead.
- err  out  1  address-range error pulse (see Optional Feature).

Behaviour:
- Reset (rst low, async) values:
  - FSM to IDLE.
  - memRead, memWrite, p0_ack, p1_ack, err = 0.
  - mem_addr, mem_wdata, p0_rdata, p1_rdata = 0.
  - last_grant = port 0.
- Reset mid-transaction: aborts the transaction with no ack. A partially written double is left as-is.
- FSM states: IDLE, ACC0, ACC1, CAPT, DONE.
- IDLE:
  - No requests: stay, strobes low.
  - Otherwise grant one port and latch its we/dbl/addr/wdata; next state ACC0.
- Arbitration, evaluated only in IDLE:
  - Only one port requesting: grant it.
  - Both requesting: grant port 1, unless last_grant = port 1, then grant port 0. This alternates under contention.
  - last_grant updates on every grant.
  - No preemption mid-transaction.
- ACC0:
  - Drive mem_addr = addr.
  - Write: memWrite = 1, mem_wdata = wdata[W-1:0]. Read: memRead = 1.
  - Next state: dbl → ACC1; single write → DONE; single read → CAPT.
- ACC1:
  - mem_addr = addr+1 (AW-bit, wraps 0x7FF → 0x000).
  - Write: memWrite = 1, mem_wdata = wdata[2W-1:W].
  - Read: memRead = 1 and capture mem_rdata into rdata[W-1:0].
  - Next: write → DONE; read → CAPT.
- CAPT:
  - Strobes low.
  - Capture mem_rdata into rdata[2W-1:W] if dbl, else into rdata[W-1:0] with upper half zeroed.
  - Next: DONE.
- DONE:
  - Strobes low; granted port's ack = 1 for one cycle; rdata presented.
  - Next: IDLE.
- Word order: addr holds the low half, addr+1 holds the high half.
- Latency, request sampled at edge N, ack high in cycle:
  - single write N+2;
  - single read N+3;
  - double write N+3;
  - double read N+4.
- Back-to-back:
  - A request held high in the ack cycle is treated as done.
  - The requester deasserts, or presents a new request, from the cycle after ack.
  - Minimum one IDLE cycle between transactions.
- memRead and memWrite are never both high. The strobes are registered outputs.
- A request changing before ack is a protocol violation; the latched copy is used.

Optional Feature:
- Macro MEM_RANGE_CHECK_EN.
- Defined:
  - A double access with addr = 2^AW−1 skips ACC1.
  - err pulses for one cycle in DONE together with ack.
  - rdata high half = 0; no second write occurs.
- Undefined:
  - addr+1 wraps to 0 as above.
  - err is tied 0.

Test Plan:
- Port 0 single write addr 0x010 data 0x00AB, then single read 0x010: memWrite one cycle with mem_addr 0x010; read ack at N+3, p0_rdata = 0x000000AB.
- Port 1 double write 0x7F0 data 0x1234ABCD, then double read: mem writes 0xABCD@0x7F0 and 0x1234@0x7F1; read returns 0x1234ABCD with ack at N+4.
- p0 and p1 both request from IDLE, both held: grants p1, p0, p1 alternate; p0_stall high until each p0_ack; strobes never overlap.
- Double write at 0x7FF: macro off → second word to 0x000, err = 0; macro on → single write to 0x7FF only, err pulses with ack.
- rst low during ACC1 of a double write: strobes drop immediately, no ack; after release FSM is in IDLE and a new p0 single read completes normally.
- Idle bus with no requests for 20 cycles: memRead = memWrite = 0 and acks = 0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter and sequencer for the single-port 16-bit data memory.
// Optional MEM_RANGE_CHECK_EN: double accesses at the top address skip the second word and pulse err.
module mem_port_arbiter #(
    parameter int W  = 16,
    parameter int AW = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p0_req,
    input  logic            p0_we,
    input  logic            p0_dbl,
    input  logic [AW-1:0]   p0_addr,
    input  logic [2*W-1:0]  p0_wdata,
    output logic            p0_ack,
    output logic [2*W-1:0]  p0_rdata,
    output logic            p0_stall,
    input  logic            p1_req,
    input  logic            p1_we,
    input  logic            p1_dbl,
    input  logic [AW-1:0]   p1_addr,
    input  logic [2*W-1:0]  p1_wdata,
    output logic            p1_ack,
    output logic [2*W-1:0]  p1_rdata,
    output logic            memRead,
    output logic            memWrite,
    output logic [AW-1:0]   mem_addr,
    output logic [W-1:0]    mem_wdata,
    input  logic [W-1:0]    mem_rdata,
    output logic            err
);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAPT, DONE} state_t;

    state_t             state;
    logic               last_grant;
    logic               cur_port;
    logic               lat_we;
    logic               lat_dbl;
    logic [AW-1:0]      lat_addr;
    logic [2*W-1:0]     lat_wdata;
    logic [W-1:0]       rdata_lo;

    logic               grant_p1;
    logic               sel_we;
    logic               sel_dbl;
    logic [AW-1:0]      sel_addr;
    logic [2*W-1:0]     sel_wdata;
    logic               skip_hi;
    logic               eff_dbl;
    logic [2*W-1:0]     final_rdata;

    // Under contention, port 1 wins unless it had the previous grant.
    assign grant_p1  = p1_req & (~p0_req | ~last_grant);
    assign sel_we    = grant_p1 ? p1_we    : p0_we;
    assign sel_dbl   = grant_p1 ? p1_dbl   : p0_dbl;
    assign sel_addr  = grant_p1 ? p1_addr  : p0_addr;
    assign sel_wdata = grant_p1 ? p1_wdata : p0_wdata;

`ifdef MEM_RANGE_CHECK_EN
    assign skip_hi = lat_dbl & (&lat_addr);
`else
    assign skip_hi = 1'b0;
`endif

    assign eff_dbl     = lat_dbl & ~skip_hi;
    assign final_rdata = eff_dbl ? {mem_rdata, rdata_lo} : {{W{1'b0}}, mem_rdata};
    assign p0_stall    = p0_req & ~p0_ack;

    // Strobes and acks are registered, so each transition loads the outputs of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            cur_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_dbl    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_lo   <= '0;
            memRead    <= 1'b0;
            memWrite   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        cur_port   <= grant_p1;
                        last_grant <= grant_p1;
                        lat_we     <= sel_we;
                        lat_dbl    <= sel_dbl;
                        lat_addr   <= sel_addr;
                        lat_wdata  <= sel_wdata;
                        mem_addr   <= sel_addr;
                        if (sel_we) begin
                            memWrite  <= 1'b1;
                            mem_wdata <= sel_wdata[W-1:0];
                        end else begin
                            memRead <= 1'b1;
                        end
                        state <= ACC0;
                    end
                end
                ACC0: begin
                    if (eff_dbl) begin
                        mem_addr <= lat_addr + AW'(1);
                        if (lat_we) begin
                            mem_wdata <= lat_wdata[2*W-1:W];
                        end
                        state <= ACC1;
                    end else begin
                        memRead  <= 1'b0;
                        memWrite <= 1'b0;
                        if (lat_we) begin
                            if (cur_port) p1_ack <= 1'b1;
                            else          p0_ack <= 1'b1;
                            err   <= skip_hi;
                            state <= DONE;
                        end else begin
                            state <= CAPT;
                        end
                    end
                end
                ACC1: begin
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                    if (lat_we) begin
                        if (cur_port) p1_ack <= 1'b1;
                        else          p0_ack <= 1'b1;
                        err   <= skip_hi;
                        state <= DONE;
                    end else begin
                        rdata_lo <= mem_rdata;
                        state    <= CAPT;
                    end
                end
                CAPT: begin
                    if (cur_port) begin
                        p1_ack   <= 1'b1;
                        p1_rdata <= final_rdata;
                    end else begin
                        p0_ack   <= 1'b1;
                        p0_rdata <= final_rdata;
                    end
                    err   <= skip_hi;
                    state <= DONE;
                end
                DONE: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    err    <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 2K x 16 memory (registered read).
// Expectations follow MEM_RANGE_CHECK_EN when the macro is defined for the build.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p0_dbl;
    logic [10:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_ack;
    logic [31:0] p0_rdata;
    logic        p0_stall;
    logic        p1_req, p1_we, p1_dbl;
    logic [10:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic [31:0] p1_rdata;
    logic        memRead, memWrite;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        err;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;
    bit stall_bad;
    logic [26:0] wlog[$];
    logic [15:0] mem_model [0:2047];

    mem_port_arbiter #(.W(16), .AW(11)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_dbl(p0_dbl), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_dbl(p1_dbl), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .memRead(memRead), .memWrite(memWrite), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memWrite) begin
            mem_model[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        if (memRead) mem_rdata <= mem_model[mem_addr];
    end

    always @(negedge clk) if (memRead && memWrite) overlap_cnt++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, counts posedges from the sampling edge until ack is seen.
    task automatic apply_stimulus(input bit port, input bit we, input bit dbl,
                                  input logic [10:0] addr, input logic [31:0] wdata,
                                  output int lat, output logic [31:0] rdata, output logic err_seen);
        bit done = 0;
        @(negedge clk);
        wlog.delete();
        stall_bad = 0;
        lat = 0;
        rdata = '0;
        err_seen = 1'b0;
        if (port) begin
            p1_we = we; p1_dbl = dbl; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_dbl = dbl; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end
        for (int i = 0; i < 12 && !done; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!port && (p0_stall !== !p0_ack)) stall_bad = 1;
            if ((port ? p1_ack : p0_ack) === 1'b1) begin
                rdata = port ? p1_rdata : p0_rdata;
                err_seen = err;
                done = 1;
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
        end
        check_output("ack_seen", 32'(done), 32'd1);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        es;
    int          p0_left, p1_left, order_code, order_cnt;
    bit          flag;

    initial begin
        rst = 1'b0;
        p0_req = 0; p0_we = 0; p0_dbl = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_dbl = 0; p1_addr = '0; p1_wdata = '0;
        repeat (2) @(negedge clk);
        check_output("rst_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check_output("rst_acks_err", {29'd0, p0_ack, p1_ack, err}, 32'd0);
        check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_output("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_output("rst_p0_rdata", p0_rdata, 32'd0);
        check_output("rst_p1_rdata", p1_rdata, 32'd0);
        rst = 1'b1;

        apply_stimulus(0, 1, 0, 11'h010, 32'h0000_00AB, lat, rd, es);
        check_output("sw_latency", 32'(lat), 32'd2);
        check_output("sw_count", 32'(wlog.size()), 32'd1);
        check_output("sw_word", 32'(wlog[0]), {5'd0, 11'h010, 16'h00AB});
        check_output("sw_stall", 32'(stall_bad), 32'd0);

        apply_stimulus(0, 0, 0, 11'h010, 32'h0, lat, rd, es);
        check_output("sr_latency", 32'(lat), 32'd3);
        check_output("sr_rdata", rd, 32'h0000_00AB);
        check_output("sr_nowrite", 32'(wlog.size()), 32'd0);

        apply_stimulus(1, 1, 1, 11'h7F0, 32'h1234_ABCD, lat, rd, es);
        check_output("dw_latency", 32'(lat), 32'd3);
        check_output("dw_count", 32'(wlog.size()), 32'd2);
        check_output("dw_lo", 32'(wlog[0]), {5'd0, 11'h7F0, 16'hABCD});
        check_output("dw_hi", 32'(wlog[1]), {5'd0, 11'h7F1, 16'h1234});

        apply_stimulus(1, 0, 1, 11'h7F0, 32'h0, lat, rd, es);
        check_output("dr_latency", 32'(lat), 32'd4);
        check_output("dr_rdata", rd, 32'h1234_ABCD);

        apply_stimulus(0, 0, 0, 11'h7F1, 32'h0, lat, rd, es);
        check_output("sr_zero_ext", rd, 32'h0000_1234);

        // Contention: last grant was port 0, so expect p1, p0, p1.
        @(negedge clk);
        wlog.delete();
        stall_bad = 0;
        p0_we = 1; p0_dbl = 0; p0_addr = 11'h020; p0_wdata = 32'h0000_5555;
        p1_we = 1; p1_dbl = 0; p1_addr = 11'h030; p1_wdata = 32'h0000_6666;
        p0_req = 1; p1_req = 1;
        p0_left = 1; p1_left = 2; order_code = 0; order_cnt = 0;
        for (int i = 0; i < 40 && (p0_left + p1_left) > 0; i++) begin
            @(negedge clk);
            if (p0_stall !== (p0_req & ~p0_ack)) stall_bad = 1;
            if (p0_ack === 1'b1) begin
                order_code = order_code * 2; order_cnt++; p0_left--;
                if (p0_left == 0) p0_req = 0;
            end
            if (p1_ack === 1'b1) begin
                order_code = order_code * 2 + 1; order_cnt++; p1_left--;
                if (p1_left == 0) p1_req = 0;
            end
        end
        check_output("arb_count", 32'(order_cnt), 32'd3);
        check_output("arb_order", 32'(order_code), 32'd5);
        check_output("arb_stall", 32'(stall_bad), 32'd0);
        check_output("arb_w0", 32'(wlog[0]), {5'd0, 11'h030, 16'h6666});
        check_output("arb_w1", 32'(wlog[1]), {5'd0, 11'h020, 16'h5555});
        check_output("arb_w2", 32'(wlog[2]), {5'd0, 11'h030, 16'h6666});

        apply_stimulus(0, 1, 1, 11'h7FF, 32'hBEEF_CAFE, lat, rd, es);
        check_output("wrap_lo", 32'(wlog[0]), {5'd0, 11'h7FF, 16'hCAFE});
`ifdef MEM_RANGE_CHECK_EN
        check_output("wrap_latency", 32'(lat), 32'd2);
        check_output("wrap_count", 32'(wlog.size()), 32'd1);
        check_output("wrap_err", 32'(es), 32'd1);
`else
        check_output("wrap_latency", 32'(lat), 32'd3);
        check_output("wrap_count", 32'(wlog.size()), 32'd2);
        check_output("wrap_hi", 32'(wlog[1]), {5'd0, 11'h000, 16'hBEEF});
        check_output("wrap_err", 32'(es), 32'd0);
`endif

        // Reset asserted while the second word of a double write is on the bus.
        @(negedge clk);
        @(negedge clk);
        p0_we = 1; p0_dbl = 1; p0_addr = 11'h100; p0_wdata = 32'h7777_8888; p0_req = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("rst_acc1_we", 32'(memWrite), 32'd1);
        check_output("rst_acc1_addr", 32'(mem_addr), 32'h101);
        rst = 1'b0;
        #1;
        check_output("rst_mid_strobes", {30'd0, memRead, memWrite}, 32'd0);
        p0_req = 0;
        flag = 0;
        repeat (3) begin
            @(negedge clk);
            if (p0_ack || p1_ack) flag = 1;
        end
        check_output("rst_mid_noack", 32'(flag), 32'd0);
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 11'h010, 32'h0, lat, rd, es);
        check_output("post_rst_latency", 32'(lat), 32'd3);
        check_output("post_rst_rdata", rd, 32'h0000_00AB);

        flag = 0;
        repeat (20) begin
            @(negedge clk);
            if (memRead || memWrite || p0_ack || p1_ack) flag = 1;
        end
        check_output("idle_quiet", 32'(flag), 32'd0);
        check_output("no_overlap", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
